// File: rtl/wii_classic_poller_if.sv
// Wishbone link between the Wii extension poller (master) and the I2C master core (slave).
interface wii_classic_poller_if;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wii_classic_poller.sv
// Drives the I2C master core to initialise a Wii Classic Controller at 0x52,
// polls its 6-byte report each tick and decodes it into active-high buttons
// and MSB-aligned analog values.
//
// state       | meaning
// S_CFG       | program prescaler and enable the core
// S_EXT_INIT  | two unencrypted-mode init transactions (F0=55, FB=00)
// S_WAIT_TICK | idle until a (possibly latched) poll tick
// S_PTR       | write register pointer 0x00
// S_GAP       | let the extension prepare its report
// S_READ      | address for read, then six data bytes
// S_DECODE    | sample published, clear retry count
// S_ABORT     | issue STOP, count the failure, maybe disconnect
module wii_classic_poller #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int I2C_HZ      = 100_000,
    parameter int POLL_CYCLES = 833_333,
    parameter int GAP_CYCLES  = 10_000,
    parameter int MAX_RETRY   = 3,
    parameter int STICK_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    wii_classic_poller_if.master bus,
    output logic [3:0]           udlr_dpad,
    output logic [3:0]           abxy_btns,
    output logic [1:0]           lr_z_btns,
    output logic [1:0]           lr_trig_dig,
    output logic [2:0]           st_sel_hm_btns,
    output logic [STICK_W-1:0]   l_trig,
    output logic [STICK_W-1:0]   r_trig,
    output logic [STICK_W-1:0]   l_stick_x,
    output logic [STICK_W-1:0]   l_stick_y,
    output logic [STICK_W-1:0]   r_stick_x,
    output logic [STICK_W-1:0]   r_stick_y,
    output logic                 connected,
    output logic                 sample_valid
);
    localparam logic [15:0] PRESCALE = 16'(CLK_HZ / (5 * I2C_HZ) - 1);
    localparam int TICK_W  = $clog2(POLL_CYCLES + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] A_TXR = 3'd3;
    localparam logic [2:0] A_CR  = 3'd4;
    localparam logic [7:0] CTR_EN = 8'h80;
    localparam logic [7:0] CR_STO = 8'h40;
    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    typedef enum logic [2:0] {
        S_CFG, S_EXT_INIT, S_WAIT_TICK, S_PTR, S_GAP, S_READ, S_DECODE, S_ABORT
    } state_t;

    typedef enum logic [1:0] {ST_TXR, ST_CR, ST_SR, ST_RXR} step_t;

    typedef struct packed {
        logic       rd;
        logic       last;
        logic [7:0] txr;
        logic [7:0] cr;
    } desc_t;

    state_t             state, resume, fail_state;
    step_t              step;
    logic [2:0]         bidx;
    logic               txn;
    logic [1:0]         cfg_idx;
    logic [RETRY_W-1:0] retry_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick_pend;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         rx_byte [0:4];

    desc_t              cur;
    logic [2:0]         iss_adr;
    logic [7:0]         iss_dat;
    logic               iss_we;
    logic               byte_done;
    logic               tick;

    logic [3:0]         dec_udlr, dec_abxy;
    logic [1:0]         dec_lrz, dec_lrt;
    logic [2:0]         dec_ssh;
    logic [STICK_W-1:0] dec_lt, dec_rt, dec_lx, dec_ly, dec_rx, dec_ry;

    // Byte sequence of each transaction: TXR value, CR command, read/last flags.
    function automatic desc_t step_desc(input state_t s, input logic t, input logic [2:0] i);
        desc_t d;
        d = '{rd: 1'b0, last: 1'b0, txr: 8'h00, cr: 8'h10};
        case (s)
            S_EXT_INIT: begin
                if (i == 3'd0) begin
                    d.txr = 8'hA4; d.cr = 8'h90;
                end else if (i == 3'd1) begin
                    d.txr = t ? 8'hFB : 8'hF0;
                end else begin
                    d.txr = t ? 8'h00 : 8'h55; d.cr = 8'h50; d.last = 1'b1;
                end
            end
            S_PTR: begin
                if (i == 3'd0) begin
                    d.txr = 8'hA4; d.cr = 8'h90;
                end else begin
                    d.cr = 8'h50; d.last = 1'b1;
                end
            end
            S_READ: begin
                if (i == 3'd0) begin
                    d.txr = 8'hA5; d.cr = 8'h90;
                end else if (i == 3'd6) begin
                    d.rd = 1'b1; d.cr = 8'h68; d.last = 1'b1;
                end else begin
                    d.rd = 1'b1; d.cr = 8'h20;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [STICK_W-1:0] align5(input logic [4:0] f);
        logic [STICK_W-1:0] r;
        r = '0;
        r[STICK_W-1 -: 5] = f;
        return r;
    endfunction

    function automatic logic [STICK_W-1:0] align6(input logic [5:0] f);
        logic [STICK_W-1:0] r;
        r = '0;
        r[STICK_W-1 -: 6] = f;
        return r;
    endfunction

    // Next Wishbone access for the current step, and byte-completion detect.
    always_comb begin
        cur     = step_desc(state, txn, bidx);
        tick    = (tick_cnt == '0);
        iss_adr = A_CR;
        iss_dat = 8'h00;
        iss_we  = 1'b0;
        if (state == S_CFG) begin
            iss_we  = 1'b1;
            iss_adr = {1'b0, cfg_idx};
            iss_dat = (cfg_idx == 2'd0) ? PRESCALE[7:0] :
                      (cfg_idx == 2'd1) ? PRESCALE[15:8] : CTR_EN;
        end else if (state == S_ABORT) begin
            iss_we  = (step == ST_CR);
            iss_dat = (step == ST_CR) ? CR_STO : 8'h00;
        end else begin
            case (step)
                ST_TXR: begin iss_we = 1'b1; iss_adr = A_TXR; iss_dat = cur.txr; end
                ST_CR:  begin iss_we = 1'b1; iss_dat = cur.cr; end
                ST_SR:  iss_adr = A_CR;
                ST_RXR: iss_adr = A_TXR;
                default: ;
            endcase
        end
        byte_done = bus.wb_cyc_o && bus.wb_ack_i &&
                    (state inside {S_EXT_INIT, S_PTR, S_READ}) &&
                    ((step == ST_SR && !bus.wb_dat_i[SR_TIP] && !cur.rd &&
                      !bus.wb_dat_i[SR_RXACK] && !bus.wb_dat_i[SR_AL]) ||
                     step == ST_RXR);
    end

    // Report decode; byte 5 comes straight off the bus so outputs land the cycle after its ack.
    always_comb begin
        dec_lx   = align6(rx_byte[0][5:0]);
        dec_ly   = align6(rx_byte[1][5:0]);
        dec_rx   = align5({rx_byte[0][7:6], rx_byte[1][7:6], rx_byte[2][7]});
        dec_ry   = align5(rx_byte[2][4:0]);
        dec_lt   = align5({rx_byte[2][6:5], rx_byte[3][7:5]});
        dec_rt   = align5(rx_byte[3][4:0]);
        dec_udlr = ~{bus.wb_dat_i[0], rx_byte[4][6], bus.wb_dat_i[1], rx_byte[4][7]};
        dec_abxy = ~{bus.wb_dat_i[4], bus.wb_dat_i[6], bus.wb_dat_i[3], bus.wb_dat_i[5]};
        dec_lrz  = ~{bus.wb_dat_i[7], bus.wb_dat_i[2]};
        dec_lrt  = ~{rx_byte[4][5], rx_byte[4][1]};
        dec_ssh  = ~{rx_byte[4][2], rx_byte[4][4], rx_byte[4][3]};
    end

    // Sequencer, Wishbone master, poll timer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_CFG; resume <= S_PTR; fail_state <= S_PTR; step <= ST_TXR;
            bidx <= '0; txn <= 1'b0; cfg_idx <= '0; retry_cnt <= '0;
            tick_cnt <= '0; tick_pend <= 1'b0; gap_cnt <= '0;
            for (int i = 0; i < 5; i++) rx_byte[i] <= '0;
            bus.wb_adr_o <= '0; bus.wb_dat_o <= '0; bus.wb_we_o <= 1'b0;
            bus.wb_stb_o <= 1'b0; bus.wb_cyc_o <= 1'b0;
            udlr_dpad <= '0; abxy_btns <= '0; lr_z_btns <= '0; lr_trig_dig <= '0;
            st_sel_hm_btns <= '0; l_trig <= '0; r_trig <= '0; l_stick_x <= '0;
            l_stick_y <= '0; r_stick_x <= '0; r_stick_y <= '0;
            connected <= 1'b0; sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (tick) begin
                tick_cnt  <= TICK_W'(POLL_CYCLES - 1);
                tick_pend <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt - 1'b1;
            end

            if (bus.wb_cyc_o) begin
                if (bus.wb_ack_i) begin
                    bus.wb_cyc_o <= 1'b0; bus.wb_stb_o <= 1'b0; bus.wb_we_o <= 1'b0;
                    bus.wb_adr_o <= '0;   bus.wb_dat_o <= '0;
                    case (state)
                        S_CFG: begin
                            if (cfg_idx == 2'd2) begin
                                state <= S_EXT_INIT; txn <= 1'b0; bidx <= '0; step <= ST_TXR;
                            end else begin
                                cfg_idx <= cfg_idx + 2'd1;
                            end
                        end
                        S_ABORT: begin
                            if (step == ST_CR) begin
                                step <= ST_SR;
                            end else if (!bus.wb_dat_i[SR_TIP]) begin
                                state <= S_WAIT_TICK;
                                if (retry_cnt >= RETRY_W'(MAX_RETRY)) begin
                                    retry_cnt <= '0; resume <= S_EXT_INIT; connected <= 1'b0;
                                    udlr_dpad <= '0; abxy_btns <= '0; lr_z_btns <= '0;
                                    lr_trig_dig <= '0; st_sel_hm_btns <= '0;
                                    l_trig <= '0; r_trig <= '0; l_stick_x <= '0;
                                    l_stick_y <= '0; r_stick_x <= '0; r_stick_y <= '0;
                                end else begin
                                    retry_cnt <= retry_cnt + 1'b1; resume <= fail_state;
                                end
                            end
                        end
                        default: begin
                            case (step)
                                ST_TXR: step <= ST_CR;
                                ST_CR:  step <= ST_SR;
                                ST_SR: begin
                                    if (!bus.wb_dat_i[SR_TIP]) begin
                                        if (!cur.rd && (bus.wb_dat_i[SR_RXACK] || bus.wb_dat_i[SR_AL])) begin
                                            fail_state <= state; state <= S_ABORT; step <= ST_CR;
                                        end else if (cur.rd) begin
                                            step <= ST_RXR;
                                        end
                                    end
                                end
                                default: begin
                                    if (bidx != 3'd6) rx_byte[bidx - 3'd1] <= bus.wb_dat_i;
                                end
                            endcase
                        end
                    endcase

                    if (byte_done) begin
                        if (!cur.last) begin
                            bidx <= bidx + 3'd1;
                            step <= (state == S_READ) ? ST_CR : ST_TXR;
                        end else begin
                            case (state)
                                S_EXT_INIT: begin
                                    if (!txn) begin
                                        txn <= 1'b1; bidx <= '0; step <= ST_TXR;
                                    end else begin
                                        connected <= 1'b1; retry_cnt <= '0;
                                        resume <= S_PTR; state <= S_WAIT_TICK;
                                    end
                                end
                                S_PTR: begin
                                    gap_cnt <= GAP_W'(GAP_CYCLES - 1); state <= S_GAP;
                                end
                                default: begin
                                    udlr_dpad <= dec_udlr; abxy_btns <= dec_abxy;
                                    lr_z_btns <= dec_lrz; lr_trig_dig <= dec_lrt;
                                    st_sel_hm_btns <= dec_ssh; l_trig <= dec_lt; r_trig <= dec_rt;
                                    l_stick_x <= dec_lx; l_stick_y <= dec_ly;
                                    r_stick_x <= dec_rx; r_stick_y <= dec_ry;
                                    sample_valid <= 1'b1; state <= S_DECODE;
                                end
                            endcase
                        end
                    end
                end
            end else begin
                case (state)
                    S_WAIT_TICK: begin
                        if (tick || tick_pend) begin
                            tick_pend <= 1'b0; state <= resume;
                            txn <= 1'b0; bidx <= '0; step <= ST_TXR;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            state <= S_READ; bidx <= '0; step <= ST_TXR;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    S_DECODE: begin
                        retry_cnt <= '0; resume <= S_PTR; state <= S_WAIT_TICK;
                    end
                    default: begin
                        bus.wb_cyc_o <= 1'b1; bus.wb_stb_o <= 1'b1; bus.wb_we_o <= iss_we;
                        bus.wb_adr_o <= iss_adr; bus.wb_dat_o <= iss_dat;
                    end
                endcase
            end
        end
    end
endmodule
